key_move_conditioner: RTL and testbench



---
 rtl/maze_pkg.sv | 35 +++
 rtl/key_debounce.sv | 57 +++++
 rtl/key_move_conditioner.sv | 179 +++++++++++++++++
 tb/tb_key_move_conditioner.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze front end: move direction encoding,
// push-button bit positions and the auto-repeat state type.
package maze_pkg;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    localparam int KEY_LEFT  = 3;
    localparam int KEY_RIGHT = 2;
    localparam int KEY_UP    = 1;
    localparam int KEY_DOWN  = 0;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Picks the highest-priority direction in a mask indexed by dir_t;
    // left is bit 0, so the lowest set bit wins.
    function automatic dir_t highest_dir(input logic [3:0] mask);
        dir_t d;
        d = LEFT;
        if (mask[LEFT])       d = LEFT;
        else if (mask[RIGHT]) d = RIGHT;
        else if (mask[UP])    d = UP;
        else if (mask[DOWN])  d = DOWN;
        return d;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: two-flop synchroniser, mismatch-run debouncer
// and a single-cycle press pulse when the debounced state goes pressed.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic held,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             pressed;
    logic             stable;
    logic [CNT_W-1:0] count;

    // Bring the asynchronous button into the clock domain; reset to released.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
        end
    end

    assign pressed = ~sync_b;

    // Flip the stable state only after an unbroken run of disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= 1'b0;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (pressed == stable) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                stable <= pressed;
                count  <= '0;
                press  <= pressed;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign held = stable;

endmodule

// File: rtl/key_move_conditioner.sv
// Turns four raw active-low buttons into one-at-a-time move tokens on a
// valid/ready handshake. Define AUTOREPEAT_EN to add typematic repeat of
// the most recently pressed direction.
module key_move_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready,
    output logic [3:0] held
);

    import maze_pkg::*;

    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;

    if (MAX_CNT > (2 ** CNT_W)) begin : g_cnt_w_too_small
        $error("CNT_W too narrow for the configured cycle counts");
    end

    logic [3:0] press_key;
    logic [3:0] press_dir;
    logic [3:0] repeat_set;
    logic [3:0] pending;
    logic [3:0] clear_mask;
    logic       stall_q;
    dir_t       dir_q;
    dir_t       cur_dir;
    logic       transfer;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .key_n(key_n[k]),
            .held (held[k]),
            .press(press_key[k])
        );
    end

    // Reorder press pulses from button positions into direction positions.
    always_comb begin
        press_dir        = '0;
        press_dir[LEFT]  = press_key[KEY_LEFT];
        press_dir[RIGHT] = press_key[KEY_RIGHT];
        press_dir[UP]    = press_key[KEY_UP];
        press_dir[DOWN]  = press_key[KEY_DOWN];
    end

`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [3:0]       held_dir;
    rpt_state_t       state_q;
    rpt_state_t       state_d;
    dir_t             rep_dir_q;
    dir_t             rep_dir_d;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_d;

    // Debounced held state reordered into direction positions.
    always_comb begin
        held_dir        = '0;
        held_dir[LEFT]  = held[KEY_LEFT];
        held_dir[RIGHT] = held[KEY_RIGHT];
        held_dir[UP]    = held[KEY_UP];
        held_dir[DOWN]  = held[KEY_DOWN];
    end

    // Repeat FSM state, target direction and timer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RPT_IDLE;
            rep_dir_q <= LEFT;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            rep_dir_q <= rep_dir_d;
            timer_q   <= timer_d;
        end
    end

    // Any fresh press retargets; otherwise time out delay/period or drop on release.
    always_comb begin
        state_d   = state_q;
        rep_dir_d = rep_dir_q;
        timer_d   = timer_q;
        if (|press_dir) begin
            state_d   = RPT_DELAY;
            rep_dir_d = highest_dir(press_dir);
            timer_d   = '0;
        end else begin
            case (state_q)
                RPT_DELAY: begin
                    if (!held_dir[rep_dir_q]) begin
                        state_d = RPT_IDLE;
                        timer_d = '0;
                    end else if (timer_q == DELAY_LAST) begin
                        state_d = RPT_REPEAT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (!held_dir[rep_dir_q]) begin
                        state_d = RPT_IDLE;
                        timer_d = '0;
                    end else if (timer_q == PERIOD_LAST) begin
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = RPT_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Raise a repeat request whenever the active timer expires on a held key.
    always_comb begin
        repeat_set = '0;
        if (!(|press_dir) && held_dir[rep_dir_q]) begin
            if ((state_q == RPT_DELAY && timer_q == DELAY_LAST) ||
                (state_q == RPT_REPEAT && timer_q == PERIOD_LAST)) begin
                repeat_set[rep_dir_q] = 1'b1;
            end
        end
    end
`else
    assign repeat_set = '0;
`endif

    assign move_valid = |pending;
    assign transfer   = move_valid & move_ready;

    // Present the locked direction while stalled, otherwise the best pending one.
    always_comb begin
        cur_dir = stall_q ? dir_q : highest_dir(pending);
    end

    assign move_dir = cur_dir;

    // Only the direction actually handed over is retired.
    always_comb begin
        clear_mask = '0;
        if (transfer) begin
            clear_mask[cur_dir] = 1'b1;
        end
    end

    // Saturating request bits (set beats clear) plus the stall lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            stall_q <= 1'b0;
            dir_q   <= LEFT;
        end else begin
            pending <= (pending & ~clear_mask) | press_dir | repeat_set;
            stall_q <= move_valid & ~move_ready;
            dir_q   <= cur_dir;
        end
    end

endmodule

// File: tb/tb_key_move_conditioner.sv
// Self-checking bench for key_move_conditioner with short debounce/repeat
// timings; the reference model follows AUTOREPEAT_EN like the design.
module tb_key_move_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int CW = 25;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ready;
    logic [3:0] held;

    key_move_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_n     (key_n),
        .move_valid(move_valid),
        .move_dir  (move_dir),
        .move_ready(move_ready),
        .held      (held)
    );

    always #5 clk = ~clk;

    int compareCount  = 0;
    int mismatchCount = 0;
    int edgeNo        = 0;
    int dutTransfers  = 0;

    // Reference model state: delayed raw samples, debounced state and
    // mismatch run length per button, request set, presented direction.
    bit [3:0] mSamp1;
    bit [3:0] mSamp2;
    bit [3:0] mStable;
    bit [3:0] mPressDir;
    bit [3:0] mPend;
    int       mRun [4];
    bit       mValid;
    int       mDir;
`ifdef AUTOREPEAT_EN
    bit       mRepActive;
    int       mRepDir;
    int       mAnchor;
`endif

    function automatic int firstSet(input bit [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    task automatic modelReset();
        mSamp1    = '1;
        mSamp2    = '1;
        mStable   = '0;
        mPressDir = '0;
        mPend     = '0;
        for (int i = 0; i < 4; i++) mRun[i] = 0;
        mValid = 1'b0;
        mDir   = 0;
`ifdef AUTOREPEAT_EN
        mRepActive = 1'b0;
        mRepDir    = 0;
        mAnchor    = 0;
`endif
    endtask

    // Advance the model by one rising edge given the inputs seen before it.
    task automatic modelEdge(input bit [3:0] k, input bit rdy, input bit rst);
        bit [3:0] newPress;
        bit [3:0] rptSet;
        bit       stallNow;
        int       prevDir;
        edgeNo++;
        if (rst) begin
            modelReset();
            return;
        end
        newPress = '0;
        rptSet   = '0;
        stallNow = mValid && !rdy;
        prevDir  = mDir;
        if (mValid && rdy) mPend[mDir] = 1'b0;
`ifdef AUTOREPEAT_EN
        if (mPressDir != 4'b0) begin
            mRepActive = 1'b1;
            mRepDir    = firstSet(mPressDir);
            mAnchor    = edgeNo;
        end else if (mRepActive) begin
            if (!mStable[3 - mRepDir]) begin
                mRepActive = 1'b0;
            end else begin
                int elapsed;
                elapsed = edgeNo - mAnchor;
                if (elapsed == RD || (elapsed > RD && (elapsed - RD) % RP == 0))
                    rptSet[mRepDir] = 1'b1;
            end
        end
`endif
        mPend = mPend | mPressDir | rptSet;
        for (int i = 0; i < 4; i++) begin
            bit pressedNow;
            pressedNow = !mSamp2[i];
            if (pressedNow != mStable[i]) begin
                mRun[i]++;
                if (mRun[i] == DB) begin
                    mStable[i] = pressedNow;
                    mRun[i]    = 0;
                    if (pressedNow) newPress[3 - i] = 1'b1;
                end
            end else begin
                mRun[i] = 0;
            end
        end
        mSamp2    = mSamp1;
        mSamp1    = k;
        mPressDir = newPress;
        mValid    = |mPend;
        mDir      = stallNow ? prevDir : firstSet(mPend);
    endtask

    task automatic checkOutput(input string tag);
        logic [1:0] expDir;
        expDir = 2'(mDir);
        compareCount++;
        assert (move_valid === mValid) else begin
            mismatchCount++;
            $error("FAIL %s_valid edge %0d observed %b expected %b", tag, edgeNo, move_valid, mValid);
        end
        compareCount++;
        assert (held === 4'(mStable)) else begin
            mismatchCount++;
            $error("FAIL %s_held edge %0d observed %b expected %b", tag, edgeNo, held, mStable);
        end
        if (mValid) begin
            compareCount++;
            assert (move_dir === expDir) else begin
                mismatchCount++;
                $error("FAIL %s_dir edge %0d observed %0d expected %0d", tag, edgeNo, move_dir, expDir);
            end
        end
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit [3:0] k, input bit rdy, input bit rst, input string tag);
        key_n      = k;
        move_ready = rdy;
        reset      = rst;
        if (!rst && move_valid === 1'b1 && rdy) dutTransfers++;
        @(posedge clk);
        modelEdge(k, rdy, rst);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int firstRise;
        bit [3:0] curKeys;
        key_n      = '1;
        move_ready = 1'b1;
        reset      = 1'b1;
        modelReset();
        $display("[TB] reset");
        repeat (3) applyStimulus(4'b1111, 1'b1, 1'b1, "reset");

        $display("[TB] short press on left");
        dutTransfers = 0;
        for (int i = 1; i <= 20; i++)
            applyStimulus((i <= 3) ? 4'b0111 : 4'b1111, 1'b1, 1'b0, "short");
        checkValue("short_xfers", dutTransfers, 0);

        $display("[TB] clean press on right");
        dutTransfers = 0;
        firstRise    = 0;
        for (int i = 1; i <= 30; i++) begin
            applyStimulus((i <= 10) ? 4'b1011 : 4'b1111, 1'b1, 1'b0, "clean");
            if (move_valid === 1'b1 && firstRise == 0) firstRise = i;
        end
        checkValue("clean_latency", firstRise, DB + 3);
        checkValue("clean_xfers", dutTransfers, 1);

        $display("[TB] simultaneous left and down under backpressure");
        dutTransfers = 0;
        for (int i = 1; i <= 30; i++)
            applyStimulus((i <= 10) ? 4'b0110 : 4'b1111, (i > 12), 1'b0, "simul");
        checkValue("simul_xfers", dutTransfers, 2);

        $display("[TB] long hold on up");
        dutTransfers = 0;
        for (int i = 1; i <= 80; i++)
            applyStimulus((i <= 60) ? 4'b1101 : 4'b1111, 1'b1, 1'b0, "hold");
`ifdef AUTOREPEAT_EN
        checkValue("hold_xfers", dutTransfers, 6);
`else
        checkValue("hold_xfers", dutTransfers, 1);
`endif

        $display("[TB] backpressure with up held");
        for (int i = 1; i <= 100; i++)
            applyStimulus((i <= 70) ? 4'b1101 : 4'b1111, (i > 50), 1'b0, "bp");

        $display("[TB] lower priority pending, then higher priority while stalled");
        for (int i = 1; i <= 40; i++)
            applyStimulus((i <= 15) ? 4'b1110 : ((i <= 25) ? 4'b0111 : 4'b1111), (i > 20), 1'b0, "nopreempt");

        $display("[TB] reset during hold on down");
        for (int i = 1; i <= 30; i++) begin
            if (i == 30) dutTransfers = 0;
            applyStimulus((i <= 45) ? 4'b1110 : 4'b1111, 1'b1, (i == 30), "rsthold");
        end
        for (int i = 31; i <= 60; i++)
            applyStimulus((i <= 45) ? 4'b1110 : 4'b1111, 1'b1, 1'b0, "rsthold");
        checkValue("rsthold_xfers", dutTransfers, 1);

        $display("[TB] randomized traffic");
        curKeys = 4'b1111;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 11) == 0) curKeys[k] = ~curKeys[k];
            end
            applyStimulus(curKeys, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0), "rand");
        end
        for (int i = 0; i < 40; i++)
            applyStimulus(4'b1111, 1'b1, 1'b0, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
